// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the RISC core: sequences fetch/decode/exec/fpu/mem/wb,
// drives all datapath strobes, and tracks memory-timeout, illegal-opcode and retire count.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             branch_cond,
    input  logic             mem_ready,
    input  logic             fpu_done,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load_jump,
    output logic             pc_load_branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             addr_sel,
    output logic             fpu_start,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_FPU    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_MOVEI = 6'd16;
    localparam logic [5:0] OP_JUMP  = 6'd21;
    localparam logic [5:0] OP_BRA   = 6'd22;
    localparam logic [5:0] OP_ADDF  = 6'd23;
    localparam logic [5:0] OP_MULF  = 6'd24;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              is_illegal, is_alu, is_fp;

    assign state      = state_q;
    assign is_illegal = opcode > OP_MULF;
    assign is_fp      = (opcode == OP_ADDF) || (opcode == OP_MULF);
    assign is_alu     = opcode inside {6'd1, 6'd2, [6'd5:6'd15], [6'd17:6'd20]};
    // This idle cycle would be the MEM_TIMEOUT-th one; a late mem_ready still wins.
    assign timeout    = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        ir_load        = 1'b0;
        pc_inc         = 1'b0;
        pc_load_jump   = 1'b0;
        pc_load_branch = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr_sel       = 1'b0;
        fpu_start      = 1'b0;
        reg_write      = 1'b0;
        wb_sel         = 2'd0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (opcode == OP_NOP || is_illegal) begin
                    state_d = S_FETCH;
                end else if (opcode == OP_JUMP) begin
                    pc_load_jump = 1'b1;
                    state_d      = S_FETCH;
                end else if (opcode == OP_MOVEI) begin
                    state_d = S_WB;
                end else if (is_fp) begin
                    fpu_start = 1'b1;
                    state_d   = S_FPU;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_BRA) begin
                    pc_load_branch = branch_cond;
                    state_d        = S_FETCH;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else if (is_alu) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FPU: begin
                if (fpu_done) state_d = S_WB;
            end
            S_MEM: begin
                addr_sel  = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                if (mem_ready) begin
                    state_d = (opcode == OP_LOAD) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (opcode == OP_LOAD)       wb_sel = 2'd1;
                else if (opcode == OP_MOVEI) wb_sel = 2'd2;
                else if (is_fp)              wb_sel = 2'd3;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            bus_error  <= 1'b0;
            retired    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (state_q == S_DECODE && is_illegal)
                illegal_op <= 1'b1;
            if (state_d == S_HALT && state_q != S_HALT)
                bus_error <= 1'b1;
            if (state_d == S_FETCH && state_q != S_FETCH)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the RISC CPU core.
- Sequences fetch, decode, execute, memory and writeback around the instruction register, register file, ALU, FPU and the shared instruction/data memory port.
- Consumes the decoded opcode from the instruction register and drives every datapath enable.
- Also provides a memory-timeout watchdog, a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15: cycles FETCH or MEM may wait with mem_ready low before the sequencer halts with a bus error.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  current opcode from the instruction register; valid from DECODE onward.
- branch_cond  in  1  BRA comparator result, valid in EXEC.
- mem_ready  in  1  memory port completes the current read/write this cycle.
- fpu_done  in  1  FPU result valid (ADDF/MULF).
- ir_load  out  1  instruction register captures fetched word.
- pc_inc  out  1  PC <= PC+1.
- pc_load_jump  out  1  PC <= immediate_jump.
- pc_load_branch  out  1  PC <= branch target.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- fpu_start  out  1  one-cycle FPU start pulse.
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = immediate, 3 = FPU.
- state  out  3  current state, for debug.
- illegal_op  out  1  sticky: an opcode 25..63 was decoded.
- bus_error  out  1  sticky: memory timeout occurred.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Opcodes: NOP 0, ADD 1, SUB 2, STORE 3, LOAD 4, MOVE 5, SGE..XOR 6-14, NOT 15, MOVEI 16, SLI 17, SRI 18, ADDI 19, SUBI 20, JUMP 21, BRA 22, ADDF 23, MULF 24. Codes 25-63 are illegal.
- ALU class: 1, 2, 5-15, 17-20.
- States (encoding): FETCH 0, DECODE 1, EXEC 2, FPU 3, MEM 4, WB 5, HALT 6.
- All outputs are combinational decodes of state, opcode and mem_ready; every output not listed for a state is 0.
- FETCH: mem_read=1, addr_sel=0. When mem_ready=1, assert ir_load=1 and pc_inc=1 that cycle and go to DECODE; otherwise stay.
- DECODE (one cycle):
  - NOP and illegal: go to FETCH; illegal also sets illegal_op.
  - JUMP: pc_load_jump=1, go to FETCH.
  - MOVEI: go to WB.
  - ADDF/MULF: fpu_start=1, go to FPU.
  - All others: go to EXEC.
- EXEC (one cycle):
  - BRA: pc_load_branch=branch_cond, go to FETCH.
  - LOAD/STORE: go to MEM.
  - ALU class: go to WB.
- FPU: hold until fpu_done=1, then go to WB. No timeout applies in FPU.
- MEM: addr_sel=1; mem_read=1 for LOAD, mem_write=1 for STORE; hold until mem_ready=1. On mem_ready, LOAD goes to WB and STORE goes to FETCH.
- WB (one cycle): reg_write=1, go to FETCH. wb_sel = 1 for LOAD, 2 for MOVEI, 3 for ADDF/MULF, 0 otherwise.
- Retire: retired increments by 1 on every transition into FETCH from DECODE, EXEC, MEM or WB. It wraps modulo 2^CNT_W and never saturates.
- Latency with mem_ready=1 and fpu_done=1 on first sample:
  - NOP, JUMP, illegal: 2 cycles.
  - MOVEI, BRA: 3 cycles.
  - ALU class, STORE, ADDF/MULF: 4 cycles.
  - LOAD: 5 cycles.
- Watchdog: a wait counter clears on entry to FETCH or MEM and increments each cycle in that state with mem_ready=0. The cycle it would reach MEM_TIMEOUT, the FSM goes to HALT and sets bus_error. If mem_ready=1 arrives on that same cycle, it wins: the transfer completes normally.
- HALT: all strobes 0; only reset exits.
- Reset (asynchronous, any state, including mid-MEM or mid-FPU):
  - state=FETCH, retired=0, illegal_op=0, bus_error=0, wait counter=0.
  - Strobes follow the FETCH decode immediately: mem_read=1, addr_sel=0.
  - The first fetch starts on the first edge after reset deasserts.

Test Plan:
- Reset, mem_ready=1, opcode stream ADD(1) -> states 0,1,2,5,0; reg_write=1 only in WB with wb_sel=0; retired=1 after 4 cycles.
- LOAD(4) with mem_ready low 3 cycles in MEM -> mem_read=1 and addr_sel=1 held 4 cycles; WB wb_sel=1; total 8 cycles; STORE(3) -> mem_write=1, no WB, retired+1.
- BRA(22): branch_cond=1 -> pc_load_branch=1 in EXEC; branch_cond=0 -> 0. JUMP(21) -> pc_load_jump=1 in DECODE, 2-cycle instruction.
- mem_ready held 0 in FETCH -> HALT (state=6) and bus_error=1 after 15 cycles. Repeat with mem_ready=1 on cycle 15 -> normal DECODE, no error.
- Opcode 6'h3F -> illegal_op=1 sticky, retired+1, next fetch proceeds. MULF(24) with fpu_done after 5 cycles -> fpu_start single pulse, wb_sel=3.
- Assert reset mid-MEM of a LOAD -> state=0, retired=0, mem_read=1, addr_sel=0 without a clock edge. retired wraps from 2^CNT_W-1 to 0 (CNT_W=4 build).
